// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: FIFO trace sink for architectural writes (GRF / DM) retired
// by the single-cycle mips core, drained over a valid/ready port.
// Optional feature macro: TRACE_SKIP_ZERO_EN (drop GRF writes to $0 silently).
// Up to two events per cycle; when both fire, DM takes the lower slot.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wdata,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wdata,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic             trace_kind,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_data,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic [15:0]      drop_cnt
);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic             pop, dm_ev, grf_ev, dm_acc, grf_acc;
    logic [PTR_W+1:0] free;
    logic [1:0]       n_push, n_drop;
    logic [16:0]      drop_sum;
    logic [PTR_W-1:0] grf_slot;
    entry_t           head;

    // Admission control, slot allocation and next-state for pointers/counters
    always_comb begin
        mem_d  = mem_q;
        pop    = (count_q != '0) && trace_ready;
        // A same-cycle pop frees its slot for this cycle's pushes
        free   = (PTR_W+2)'(DEPTH) - {1'b0, count_q} + (PTR_W+2)'(pop);
        dm_ev  = dm_we;
`ifdef TRACE_SKIP_ZERO_EN
        grf_ev = grf_we && (grf_addr != 5'd0);
`else
        grf_ev = grf_we;
`endif
        dm_acc   = dm_ev && (free != '0);
        // GRF needs a second slot when DM already took one
        grf_acc  = grf_ev && (free > (PTR_W+2)'(dm_acc));
        grf_slot = dm_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (dm_acc)
            mem_d[wr_ptr_q] = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};
        if (grf_acc)
            mem_d[grf_slot] = '{kind: 1'b0, pc: grf_pc, addr: {27'b0, grf_addr}, data: grf_wdata};
        n_push   = {1'b0, dm_acc} + {1'b0, grf_acc};
        n_drop   = ({1'b0, dm_ev} + {1'b0, grf_ev}) - n_push;
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
        // Saturating drop counter: compute one bit wider, clamp on carry
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Control state: pointers, occupancy and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents never reach outputs unless counted as valid
    always_ff @(posedge clk) begin
        if (!reset)
            mem_q <= mem_d;
    end

    // Show-ahead head, zeroed while empty so stale slots never leak out
    always_comb begin
        head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

    assign trace_valid = (count_q != '0);
    assign trace_kind  = head.kind;
    assign trace_pc    = head.pc;
    assign trace_addr  = head.addr;
    assign trace_data  = head.data;
    assign count       = count_q;
    assign full        = (count_q == (PTR_W+1)'(DEPTH));
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: table-driven vectors plus hand-written corner
// sequences; a reference queue holds expected entries in commit order.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic        clk = 0;
    logic        reset;
    logic        grf_we, dm_we, trace_ready;
    logic [31:0] grf_pc, grf_wdata, dm_pc, dm_addr, dm_wdata;
    logic [4:0]  grf_addr;
    logic        trace_valid, trace_kind, full;
    logic [31:0] trace_pc, trace_addr, trace_data;
    logic [PTR_W:0] count;
    logic [15:0] drop_cnt;

    wb_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_kind(trace_kind),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .count(count), .full(full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          gwe;
        logic [4:0]  ga;
        logic [31:0] gd, gp;
        bit          dwe;
        logic [31:0] da, dd, dp;
        bit          rdy;
        int          exp_count;
    } vec_t;

    ent_t sb[$];
    int   mdrop;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit gwe, logic [4:0] ga, logic [31:0] gd, logic [31:0] gp,
                                bit dwe, logic [31:0] da, logic [31:0] dd, logic [31:0] dp,
                                bit rdy, int ec);
        vec_t v;
        v.gwe = gwe; v.ga = ga; v.gd = gd; v.gp = gp;
        v.dwe = dwe; v.da = da; v.dd = dd; v.dp = dp;
        v.rdy = rdy; v.exp_count = ec;
        return v;
    endfunction

    // Compare all observable state against the reference model (called at negedge)
    task automatic check_state();
        ent_t e;
        e = (sb.size() > 0) ? sb[0] : '0;
        chk("valid", {31'b0, trace_valid}, {31'b0, sb.size() > 0});
        chk("count", {27'b0, count}, sb.size());
        chk("full", {31'b0, full}, {31'b0, sb.size() == DEPTH});
        chk("drop_cnt", {16'b0, drop_cnt}, mdrop);
        chk("head_kind", {31'b0, trace_kind}, {31'b0, e.kind});
        chk("head_pc", trace_pc, e.pc);
        chk("head_addr", trace_addr, e.addr);
        chk("head_data", trace_data, e.data);
    endtask

    // Drive one cycle of stimulus (entered right after a negedge), update model
    task automatic step(input vec_t v);
        bit pop, gev;
        int free;
        grf_we = v.gwe; grf_addr = v.ga; grf_wdata = v.gd; grf_pc = v.gp;
        dm_we = v.dwe; dm_addr = v.da; dm_wdata = v.dd; dm_pc = v.dp;
        trace_ready = v.rdy;
        pop  = v.rdy && sb.size() > 0;
        free = DEPTH - sb.size() + int'(pop);
        if (pop) void'(sb.pop_front());
`ifdef TRACE_SKIP_ZERO_EN
        gev = v.gwe && v.ga != 5'd0;
`else
        gev = v.gwe;
`endif
        if (v.dwe) begin
            if (free > 0) begin sb.push_back('{1'b1, v.dp, v.da, v.dd}); free--; end
            else if (mdrop < 65535) mdrop++;
        end
        if (gev) begin
            if (free > 0) sb.push_back('{1'b0, v.gp, {27'b0, v.ga}, v.gd});
            else if (mdrop < 65535) mdrop++;
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset(input int n, input bit with_dm);
        reset = 1; dm_we = with_dm; dm_addr = 32'hDEAD_0000; dm_wdata = 32'h5555_AAAA;
        dm_pc = 32'h0000_4444; grf_we = 0; trace_ready = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 0; dm_we = 0;
        sb.delete();
        mdrop = 0;
        check_state();
    endtask

    function automatic vec_t idle(bit rdy);
        return mk(0, 5'd0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 32'd0, rdy, 0);
    endfunction

    function automatic vec_t gw(int i, bit rdy);
        return mk(1, 5'(i + 1), 32'hA000_0000 + i, 32'h0000_3000 + 4 * i,
                  0, 32'd0, 32'd0, 32'd0, rdy, 0);
    endfunction

    initial begin
        int zero_cnt;
        reset = 1; grf_we = 0; dm_we = 0; trace_ready = 0;
        grf_pc = 0; grf_addr = 0; grf_wdata = 0; dm_pc = 0; dm_addr = 0; dm_wdata = 0;
        mdrop = 0;
        @(negedge clk);
        do_reset(2, 0);

`ifdef TRACE_SKIP_ZERO_EN
        zero_cnt = 0;
`else
        zero_cnt = 1;
`endif
        // Expected count column is hand-derived from the behaviour rules
        tbl[0]  = mk(1, 5'd8, 32'h0000_1234, 32'h0000_3000, 0, 0, 0, 0, 0, 1);
        tbl[1]  = idle(1); tbl[1].exp_count = 0;
        tbl[2]  = mk(1, 5'd5, 32'h0000_0055, 32'h0000_3008, 1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_3004, 0, 2);
        tbl[3]  = idle(1); tbl[3].exp_count = 1;
        tbl[4]  = idle(1); tbl[4].exp_count = 0;
        tbl[5]  = mk(1, 5'd0, 32'hFFFF_FFFF, 32'h0000_300C, 0, 0, 0, 0, 0, zero_cnt);
        tbl[6]  = idle(1); tbl[6].exp_count = 0;
        tbl[7]  = idle(1); tbl[7].exp_count = 0;
        tbl[8]  = mk(0, 5'd0, 0, 0, 1, 32'h0000_0200, 32'h1111_2222, 32'h0000_3010, 1, 1);
        tbl[9]  = mk(1, 5'd31, 32'h7777_0000, 32'h0000_3018, 1, 32'h0000_0204, 32'h3333_4444, 32'h0000_3014, 1, 2);
        tbl[10] = idle(1); tbl[10].exp_count = 1;
        tbl[11] = idle(1); tbl[11].exp_count = 0;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i]);
            chk($sformatf("tbl%0d_count", i), {27'b0, count}, tbl[i].exp_count);
            if (i == 0) begin
                chk("t1_addr", trace_addr, 32'd8);
                chk("t1_data", trace_data, 32'h0000_1234);
            end
            if (i == 2) chk("t4_first_kind", {31'b0, trace_kind}, 32'd1);
            if (i == 3) chk("t4_second_kind", {31'b0, trace_kind}, 32'd0);
        end

        // Fill to full, then overflow by one
        for (int i = 0; i < DEPTH; i++) step(gw(i, 0));
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_count", {27'b0, count}, DEPTH);
        step(gw(99, 0));
        chk("ovf_drop", {16'b0, drop_cnt}, 32'd1);
        chk("ovf_count", {27'b0, count}, DEPTH);

        // Full with pop and DM push in the same cycle: both accepted
        step(mk(0, 0, 0, 0, 1, 32'h0000_0300, 32'hBEEF_0001, 32'h0000_5000, 1, 0));
        chk("fullpop_count", {27'b0, count}, DEPTH);
        chk("fullpop_drop", {16'b0, drop_cnt}, 32'd1);

        // One free slot with both events: DM kept, GRF dropped
        step(idle(1));
        step(mk(1, 5'd9, 32'h0000_0009, 32'h0000_5008, 1, 32'h0000_0304, 32'hBEEF_0002, 32'h0000_5004, 0, 0));
        chk("free1_drop", {16'b0, drop_cnt}, 32'd2);
        // Full with pop and both events: again DM kept, GRF dropped
        step(mk(1, 5'd10, 32'h0000_000A, 32'h0000_5010, 1, 32'h0000_0308, 32'hBEEF_0003, 32'h0000_500C, 1, 0));
        chk("fullpop2_drop", {16'b0, drop_cnt}, 32'd3);

        // Both dropped every cycle until the counter saturates
        for (int i = 0; i < 32770; i++)
            step(mk(1, 5'd3, 32'd0, 32'd0, 1, 32'd0, 32'd0, 32'd0, 0, 0));
        chk("drop_sat", {16'b0, drop_cnt}, 32'h0000_FFFF);

        // Drain everything, comparing each head against commit order
        for (int i = 0; i < DEPTH; i++) step(idle(1));
        chk("drain_empty", {31'b0, trace_valid}, 32'd0);

        // Mid-stream reset with a DM write in the reset cycle
        for (int i = 0; i < 5; i++) step(gw(i + 40, 0));
        chk("pre_rst_count", {27'b0, count}, 32'd5);
        do_reset(1, 1);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, trace_valid}, 32'd0);
        chk("rst_drop", {16'b0, drop_cnt}, 32'd0);

        // Pointer wrap after reset: push/pop stream across the boundary
        for (int i = 0; i < 40; i++) step(gw(i + 60, (i % 3) != 0));
        for (int i = 0; i < DEPTH + 2; i++) step(idle(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
